// File: rtl/axi_rd_arb_pkg.sv
// Shared AXI read-side constants and types for the instruction/data read arbiter.
package axi_rd_arb_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    // Burst shape is fixed outside this block; kept here so the wrapper uses one source.
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_VALID = 1'b1
    } ar_state_t;

    function automatic logic [2:0] ar_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_rd_arb_rr_arb2.sv
// Two-input round-robin arbiter; index 0 is instruction, index 1 is data.
module rr_arb2 (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_d;  // 1 when data held the most recent grant

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_d ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_d <= 1'b0;
        end else if (|gnt) begin
            last_d <= gnt[1];
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// Merges instruction and data read requests onto one AXI AR channel and routes
// R responses back by ID; one read in flight per requester.
module axi_rd_arb #(
    parameter logic [3:0] ID_INST = axi_rd_arb_pkg::ID_INST,
    parameter logic [3:0] ID_DATA = axi_rd_arb_pkg::ID_DATA
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_busy,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output axi_rd_arb_pkg::ar_state_t ar_state_dbg
);
    import axi_rd_arb_pkg::*;

    // Handshakes: AR moves on arvalid & arready; a request is taken on req & addr_ok;
    // R beats are taken whenever rvalid, since rready is always high outside reset.

    ar_state_t  ar_state;
    logic       out_i, out_d;
    logic [1:0] elig, gnt;
    logic       rsp_i, rsp_d;

    assign elig[0] = inst_req & ~out_i & (ar_state == AR_IDLE);
    assign elig[1] = data_req & ~out_d & ~wr_busy & (ar_state == AR_IDLE);

    rr_arb2 u_rr_arb2 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (elig),
        .gnt     (gnt)
    );

    assign inst_addr_ok = gnt[0];
    assign data_addr_ok = gnt[1];
    assign arvalid      = (ar_state == AR_VALID);
    assign rready       = aresetn;
    assign ar_state_dbg = ar_state;

    // Only final beats for a read we actually issued count as completions.
    assign rsp_i = rvalid & rlast & (rid == ID_INST) & out_i;
    assign rsp_d = rvalid & rlast & (rid == ID_DATA) & out_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_state <= AR_IDLE;
            arid     <= 4'd0;
            araddr   <= 32'd0;
            arsize   <= 3'd0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (gnt[1]) begin
                        arid     <= ID_DATA;
                        araddr   <= data_addr;
                        arsize   <= ar_size(data_size);
                        ar_state <= AR_VALID;
                    end else if (gnt[0]) begin
                        arid     <= ID_INST;
                        araddr   <= inst_addr;
                        arsize   <= ar_size(inst_size);
                        ar_state <= AR_VALID;
                    end
                end
                AR_VALID: begin
                    if (arready) begin
                        ar_state <= AR_IDLE;
                    end
                end
                default: ar_state <= AR_IDLE;
            endcase
        end
    end

    // A grant can only hit a clear flag, so set and clear never collide on one ID.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_i        <= 1'b0;
            out_d        <= 1'b0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= 32'd0;
            data_rdata   <= 32'd0;
        end else begin
            out_i        <= (out_i & ~rsp_i) | gnt[0];
            out_d        <= (out_d & ~rsp_d) | gnt[1];
            inst_data_ok <= rsp_i;
            data_data_ok <= rsp_d;
            if (rsp_i) inst_rdata <= rdata;
            if (rsp_d) data_rdata <= rdata;
        end
    end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: grants, ordering, response routing and reset.
module tb_axi_rd_arb;
    import axi_rd_arb_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'd0;
    logic [1:0]  inst_size = 2'd0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic [31:0] data_addr = 32'd0;
    logic [1:0]  data_size = 2'd0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        wr_busy = 1'b0;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'd0;
    logic [31:0] rdata = 32'd0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    ar_state_t   ar_state_dbg;

    int tests  = 0;
    int failed = 0;

    axi_rd_arb dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_size    (inst_size),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .wr_busy      (wr_busy),
        .arid         (arid),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready),
        .ar_state_dbg (ar_state_dbg)
    );

    always #5 aclk = ~aclk;

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        #0;
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic last);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        rlast  = last;
    endtask

    task automatic rsp_done();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    // Complete an AR handshake from the cycle right after a grant.
    task automatic ar_accept();
        arready = 1'b1;
        step();
        arready = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_id;

        // ---- reset state ----
        #2;
        #1;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_inst_ok", inst_data_ok, 1'b0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        step();
        aresetn = 1'b1;
        #1;
        chk("rready_up", rready, 1'b1);
        chk("idle_state", ar_state_dbg, AR_IDLE);

        // ---- instruction read alone ----
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        inst_size = 2'd2;
        #1;
        chk("i_addr_ok", inst_addr_ok, 1'b1);
        chk("i_no_d_ok", data_addr_ok, 1'b0);
        step();
        inst_req = 1'b0;
        #1;
        chk("i_arvalid", arvalid, 1'b1);
        chk("i_araddr", araddr, 32'h1C00_0000);
        chk("i_arid", arid, 4'd0);
        chk("i_arsize", arsize, 3'd2);
        step();
        chk("i_arvalid_hold", arvalid, 1'b1);
        chk("i_araddr_hold", araddr, 32'h1C00_0000);
        ar_accept();
        #1;
        chk("i_ar_done", arvalid, 1'b0);
        inst_req = 1'b1;
        #1;
        chk("i_busy_no_ok", inst_addr_ok, 1'b0);
        inst_req = 1'b0;
        beat(4'd0, 32'hDEAD_0001, 1'b0);
        step();
        #1;
        chk("nonlast_ignored", inst_data_ok, 1'b0);
        beat(4'd5, 32'hDEAD_0002, 1'b1);
        step();
        #1;
        chk("badid_ignored", inst_data_ok, 1'b0);
        beat(4'd0, 32'h0280_0C0C, 1'b1);
        #1;
        chk("i_ok_not_yet", inst_data_ok, 1'b0);
        step();
        rsp_done();
        #1;
        chk("i_data_ok", inst_data_ok, 1'b1);
        chk("i_rdata", inst_rdata, 32'h0280_0C0C);
        step();
        chk("i_data_ok_pulse", inst_data_ok, 1'b0);
        chk("i_rdata_hold", inst_rdata, 32'h0280_0C0C);

        // ---- tie: fresh reset so the pointer starts at inst ----
        aresetn = 1'b0;
        step();
        aresetn   = 1'b1;
        inst_req  = 1'b1;
        data_req  = 1'b1;
        inst_addr = 32'h0000_1000;
        data_addr = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            exp_id = (k % 2 == 0) ? 4'd1 : 4'd0;
            #1;
            chk("tie_gnt_i", inst_addr_ok, (exp_id == 4'd0));
            chk("tie_gnt_d", data_addr_ok, (exp_id == 4'd1));
            step();
            arready = 1'b1;
            if (k > 0) beat((exp_id == 4'd1) ? 4'd0 : 4'd1, 32'h5000_0000 + k, 1'b1);
            else rsp_done();
            #1;
            chk("tie_arid", arid, exp_id);
            chk("tie_bubble", inst_addr_ok | data_addr_ok, 1'b0);
            step();
            arready = 1'b0;
            rsp_done();
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        beat(4'd0, 32'h0000_0BAD, 1'b1);
        step();
        rsp_done();
        // Data alone, so the following tie must go to inst.
        data_req = 1'b1;
        #1;
        chk("d_alone_ok", data_addr_ok, 1'b1);
        step();
        data_req = 1'b0;
        ar_accept();
        beat(4'd1, 32'h0000_0D0D, 1'b1);
        step();
        rsp_done();
        inst_req = 1'b1;
        data_req = 1'b1;
        #1;
        chk("tie2_gnt_i", inst_addr_ok, 1'b1);
        chk("tie2_gnt_d", data_addr_ok, 1'b0);
        step();
        inst_req = 1'b0;
        data_req = 1'b0;
        ar_accept();
        beat(4'd0, 32'h0000_0E0E, 1'b1);
        step();
        rsp_done();
        step();

        // ---- out-of-order responses ----
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0100;
        step();
        inst_req = 1'b0;
        ar_accept();
        data_req  = 1'b1;
        data_addr = 32'h0000_0200;
        #1;
        chk("ooo_d_ok", data_addr_ok, 1'b1);
        step();
        data_req = 1'b0;
        chk("ooo_d_arid", arid, 4'd1);
        chk("ooo_d_araddr", araddr, 32'h0000_0200);
        ar_accept();
        beat(4'd1, 32'hAAAA_5555, 1'b1);
        step();
        beat(4'd0, 32'h1234_5678, 1'b1);
        #1;
        chk("ooo_d_pulse", data_data_ok, 1'b1);
        chk("ooo_i_quiet", inst_data_ok, 1'b0);
        chk("ooo_d_rdata", data_rdata, 32'hAAAA_5555);
        step();
        rsp_done();
        #1;
        chk("ooo_i_pulse", inst_data_ok, 1'b1);
        chk("ooo_d_single", data_data_ok, 1'b0);
        chk("ooo_i_rdata", inst_rdata, 32'h1234_5678);
        step();
        chk("ooo_i_single", inst_data_ok, 1'b0);
        chk("ooo_d_hold", data_rdata, 32'hAAAA_5555);

        // ---- write busy blocks data reads ----
        wr_busy  = 1'b1;
        data_req = 1'b1;
        inst_req = 1'b1;
        #1;
        chk("wb_d_blocked", data_addr_ok, 1'b0);
        chk("wb_i_granted", inst_addr_ok, 1'b1);
        step();
        inst_req = 1'b0;
        ar_accept();
        #1;
        chk("wb_d_still", data_addr_ok, 1'b0);
        step();
        wr_busy = 1'b0;
        #1;
        chk("wb_d_after", data_addr_ok, 1'b1);
        step();
        data_req = 1'b0;
        ar_accept();
        beat(4'd0, 32'h0000_0001, 1'b1);
        step();
        beat(4'd1, 32'h0000_0002, 1'b1);
        step();
        rsp_done();
        step();

        // ---- same-ID back-to-back ----
        inst_req = 1'b1;
        step();
        inst_req = 1'b0;
        ar_accept();
        beat(4'd0, 32'h0000_CAFE, 1'b1);
        inst_req = 1'b1;
        #1;
        chk("b2b_hold_off", inst_addr_ok, 1'b0);
        step();
        rsp_done();
        #1;
        chk("b2b_accept", inst_addr_ok, 1'b1);
        chk("b2b_data_ok", inst_data_ok, 1'b1);
        step();
        inst_req = 1'b0;
        ar_accept();
        beat(4'd0, 32'h0000_BEEF, 1'b1);
        step();
        rsp_done();
        step();

        // ---- reset mid-operation ----
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0300;
        step();
        inst_req = 1'b0;
        #1;
        chk("mid_arvalid", arvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_arvalid", arvalid, 1'b0);
        chk("mid_rst_rdata", inst_rdata, 32'd0);
        step();
        aresetn = 1'b1;
        beat(4'd0, 32'hFEED_F00D, 1'b1);
        step();
        rsp_done();
        #1;
        chk("late_no_ok", inst_data_ok, 1'b0);
        chk("late_no_data", inst_rdata, 32'd0);
        step();
        chk("late_no_ok2", inst_data_ok, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
